// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Control unit for a multi-cycle RV32I datapath. A single FSM steps every
// instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB (or TRAP on an illegal
// encoding) and drives the datapath mux selects and write strobes per state.
//
// Parameters
//   MEM_HANDSHAKE  1: memory accesses finish on mem_ready
//                  0: accesses take exactly MEM_LAT cycles, mem_ready ignored
//   MEM_LAT        access length in cycles when MEM_HANDSHAKE=0 (>=1)
//   TRAP_STICKY    1: TRAP is held until reset
//                  0: TRAP lasts one cycle, loads the trap vector, then FETCH
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   opcode/funct3/funct7         instruction register fields
//   mem_ready                    imem/dmem access complete
//   branch_taken                 ALU compare result, sampled in EXEC
//   stall                        freeze FSM and suppress write strobes
//   imem_req, mem_read/write     memory requests (levels)
//   ir_write, pc_write, reg_write  write strobes
//   pc_src, alu_src_a/b, alu_op, wb_sel  datapath mux selects
//   illegal_instr                high while in TRAP
//   state_o                      current state (IDLE=0 .. TRAP=6)
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 1,
    parameter bit          TRAP_STICKY   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       branch_taken,
    input  logic       stall,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] wb_sel,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3, C_BR  = 4'd4,
        C_LD  = 4'd5, C_ST    = 4'd6, C_OPI = 4'd7, C_OP   = 4'd8, C_ILL = 4'd9
    } class_e;

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    class_e           decoded_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             access_done_s;
    logic             ir_write_s, pc_write_s, reg_write_s;

    // Instruction classification; reserved funct fields make an encoding illegal.
    function automatic class_e classify(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
        class_e c;
        case (op)
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            7'b1100011: c = ((f3 == 3'b010) || (f3 == 3'b011)) ? C_ILL : C_BR;
            7'b0000011: c = C_LD;
            7'b0100011: c = C_ST;
            7'b0010011: c = C_OPI;
            7'b0110011: c = ((f7 == 7'b0000000) || (f7 == 7'b0100000)) ? C_OP : C_ILL;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    assign decoded_s = classify(opcode, funct3, funct7);

    // Memory access completion: handshake, or the wait counter reaching its last cycle.
    always_comb begin
        if (MEM_HANDSHAKE) begin
            access_done_s = mem_ready;
        end else begin
            access_done_s = (cnt_q == LAST_CNT);
        end
    end

    // State, latched instruction class and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            class_q <= C_LUI;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; stall freezes state and counter, and hides mem_ready.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH:  state_d = access_done_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    class_d = decoded_s;
                    state_d = (decoded_s == C_ILL) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    case (class_q)
                        C_BR:       state_d = S_FETCH;
                        C_LD, C_ST: state_d = S_MEM;
                        default:    state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    if (access_done_s) begin
                        state_d = (class_q == C_ST) ? S_FETCH : S_WB;
                    end else begin
                        state_d = S_MEM;
                    end
                end
                S_WB:     state_d = S_FETCH;
                S_TRAP:   state_d = TRAP_STICKY ? S_TRAP : S_FETCH;
                default:  state_d = S_IDLE;
            endcase
            // The counter measures time spent in the current state only.
            if (state_d != state_q) begin
                cnt_d = {CNT_W{1'b0}};
            end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Datapath controls from state and latched class; strobes are gated by stall below.
    always_comb begin
        imem_req      = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        wb_sel        = 2'b00;
        reg_write_s   = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req   = 1'b1;
                ir_write_s = access_done_s;
                pc_write_s = access_done_s;
            end
            S_EXEC: begin
                case (class_q)
                    C_BR: begin
                        alu_op     = 2'b01;
                        pc_write_s = branch_taken;
                        pc_src     = 2'b01;
                    end
                    C_JAL, C_JALR: begin
                        alu_src_a  = (class_q == C_JAL);
                        alu_src_b  = 2'b01;
                        pc_write_s = 1'b1;
                        pc_src     = 2'b10;
                    end
                    C_LD, C_ST: alu_src_b = 2'b01;
                    C_OP:       alu_op    = 2'b10;
                    C_OPI: begin
                        alu_op    = 2'b10;
                        alu_src_b = 2'b01;
                    end
                    C_LUI: begin
                        alu_op    = 2'b11;
                        alu_src_b = 2'b01;
                    end
                    C_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b01;
                    end
                    default: alu_op = 2'b00;
                endcase
            end
            S_MEM: begin
                mem_read  = (class_q == C_LD);
                mem_write = (class_q == C_ST);
            end
            S_WB: begin
                reg_write_s = 1'b1;
                case (class_q)
                    C_LD:          wb_sel = 2'b01;
                    C_JAL, C_JALR: wb_sel = 2'b10;
                    default:       wb_sel = 2'b00;
                endcase
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                if (TRAP_STICKY) begin
                    pc_write_s = 1'b0;
                end else begin
                    pc_write_s = 1'b1;
                    pc_src     = 2'b11;
                end
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign ir_write  = ir_write_s  & ~stall;
    assign pc_write  = pc_write_s  & ~stall;
    assign reg_write = reg_write_s & ~stall;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm. Two instances: u_hs (handshake memory,
// sticky trap) and u_lat (fixed 3-cycle memory, one-shot trap). For each
// directed instruction the bench builds the expected per-cycle output trace
// from the instruction class and the memory/trap configuration, and a
// compare process checks the selected instance on every cycle.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       a_src;
        logic [1:0] b_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       illegal;
    } outs_t;

    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;
    localparam int K_LD = 5, K_ST = 6, K_OPI = 7, K_OP = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       stall = 1'b0;

    logic [2:0] h_st, l_st;
    logic       h_ireq, h_irw, h_pcw, h_asrc, h_mr, h_mw, h_rw, h_ill;
    logic       l_ireq, l_irw, l_pcw, l_asrc, l_mr, l_mw, l_rw, l_ill;
    logic [1:0] h_pcs, h_bsrc, h_aop, h_wbs, l_pcs, l_bsrc, l_aop, l_wbs;
    outs_t      out_hs, out_lat;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .MEM_LAT(1), .TRAP_STICKY(1'b1)) u_hs (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .stall(stall),
        .imem_req(h_ireq), .ir_write(h_irw), .pc_write(h_pcw), .pc_src(h_pcs),
        .alu_src_a(h_asrc), .alu_src_b(h_bsrc), .alu_op(h_aop), .mem_read(h_mr),
        .mem_write(h_mw), .wb_sel(h_wbs), .reg_write(h_rw), .illegal_instr(h_ill),
        .state_o(h_st));

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .MEM_LAT(3), .TRAP_STICKY(1'b0)) u_lat (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .stall(stall),
        .imem_req(l_ireq), .ir_write(l_irw), .pc_write(l_pcw), .pc_src(l_pcs),
        .alu_src_a(l_asrc), .alu_src_b(l_bsrc), .alu_op(l_aop), .mem_read(l_mr),
        .mem_write(l_mw), .wb_sel(l_wbs), .reg_write(l_rw), .illegal_instr(l_ill),
        .state_o(l_st));

    assign out_hs  = {h_st, h_ireq, h_irw, h_pcw, h_pcs, h_asrc, h_bsrc, h_aop,
                      h_mr, h_mw, h_wbs, h_rw, h_ill};
    assign out_lat = {l_st, l_ireq, l_irw, l_pcw, l_pcs, l_asrc, l_bsrc, l_aop,
                      l_mr, l_mw, l_wbs, l_rw, l_ill};

    // Expectation / literal-check channel from the driver to the compare process
    outs_t exp_cur = '0;
    logic  exp_valid = 1'b0;
    logic  sel_r = 1'b0;
    string tname = "none";
    logic  lit_valid = 1'b0;
    string lit_name = "none";
    int    lit_act = 0, lit_exp = 0;

    // Model configuration of the selected instance
    bit    hs_m = 1'b1;
    int    lat_m = 1;
    bit    sticky_m = 1'b1;

    // Observed activity, counted only by the compare process
    int    checks = 0, errors = 0;
    int    rw_cnt = 0, pcw_cnt = 0, mr_cnt = 0, mw_cnt = 0, ill_cnt = 0, wb_cnt = 0;
    int    b_rw, b_pcw, b_mr, b_mw, b_ill, b_wb;

    // Compare process: selected DUT against the model trace, plus literal checks
    always @(negedge clk) begin
        outs_t act;
        act = sel_r ? out_lat : out_hs;
        if (exp_valid) begin
            checks++;
            if (act !== exp_cur) begin
                errors++;
                $display("FAIL %s t=%0t: actual=%b required=%b", tname, $time, act, exp_cur);
            end
            if (act.reg_write === 1'b1) rw_cnt++;
            if (act.pc_write === 1'b1) pcw_cnt++;
            if (act.mem_read === 1'b1) mr_cnt++;
            if (act.mem_write === 1'b1) mw_cnt++;
            if (act.illegal === 1'b1) ill_cnt++;
            if (act.st === 3'd5) wb_cnt++;
        end
        if (lit_valid) begin
            checks++;
            if (lit_act != lit_exp) begin
                errors++;
                $display("FAIL %s: actual=%0d required=%0d", lit_name, lit_act, lit_exp);
            end
        end
    end

    function automatic outs_t o_st(input int s);
        outs_t o;
        o = '0;
        o.st = s[2:0];
        return o;
    endfunction

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
        case (op)
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? K_ILL : K_BR;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b0010011: return K_OPI;
            7'b0110011: return (f7 == 7'b0000000 || f7 == 7'b0100000) ? K_OP : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    task automatic step(input outs_t e, input logic rdy, input logic bt, input logic stl);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        branch_taken = bt;
        stall = stl;
        exp_cur = e;
        exp_valid = 1'b1;
    endtask

    // Reset cycle (outputs zero while rst_n low) then one IDLE cycle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        exp_cur = '0;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cur = '0;
    endtask

    // Memory access: stalled cycles (ready high but ignored), wait cycles, done cycle.
    task automatic access(input outs_t base, input outs_t done_o, input int late, input int stl_n);
        for (int i = 0; i < stl_n; i++) step(base, 1'b1, 1'b0, 1'b1);
        if (hs_m) begin
            for (int i = 0; i < late; i++) step(base, 1'b0, 1'b0, 1'b0);
            step(done_o, 1'b1, 1'b0, 1'b0);
        end else begin
            for (int i = 1; i < lat_m; i++) step(base, 1'b1, 1'b0, 1'b0);
            step(done_o, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_instr(input string nm, input logic sel, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7, input logic bt,
                             input int late, input int stl_fetch, input int stl_mem,
                             input bit rst_mem);
        outs_t e, d;
        int    cls;
        tname = nm;
        sel_r = sel;
        hs_m = !sel;
        lat_m = sel ? 3 : 1;
        sticky_m = !sel;
        b_rw = rw_cnt; b_pcw = pcw_cnt; b_mr = mr_cnt;
        b_mw = mw_cnt; b_ill = ill_cnt; b_wb = wb_cnt;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        do_reset();
        e = o_st(1);
        e.imem_req = 1'b1;
        d = e;
        d.ir_write = 1'b1;
        d.pc_write = 1'b1;
        access(e, d, late, stl_fetch);
        step(o_st(2), 1'b0, 1'b0, 1'b0);
        cls = classify(op, f3, f7);
        if (cls == K_ILL) begin
            e = o_st(6);
            e.illegal = 1'b1;
            if (sticky_m) begin
                for (int i = 0; i < 20; i++) step(e, 1'b1, 1'b0, 1'b0);
            end else begin
                e.pc_write = 1'b1;
                e.pc_src = 2'b11;
                step(e, 1'b0, 1'b0, 1'b0);
                e = o_st(1);
                e.imem_req = 1'b1;
                step(e, 1'b0, 1'b0, 1'b0);
            end
        end else begin
            e = o_st(3);
            case (cls)
                K_BR: begin e.alu_op = 2'b01; e.pc_write = bt; e.pc_src = 2'b01; end
                K_JAL, K_JALR: begin
                    e.a_src = (cls == K_JAL);
                    e.b_src = 2'b01;
                    e.pc_write = 1'b1;
                    e.pc_src = 2'b10;
                end
                K_LD, K_ST: e.b_src = 2'b01;
                K_OP:    e.alu_op = 2'b10;
                K_OPI:   begin e.alu_op = 2'b10; e.b_src = 2'b01; end
                K_LUI:   begin e.alu_op = 2'b11; e.b_src = 2'b01; end
                default: begin e.a_src = 1'b1; e.b_src = 2'b01; end
            endcase
            step(e, 1'b0, bt, 1'b0);
            if (cls == K_LD || cls == K_ST) begin
                e = o_st(4);
                e.mem_read = (cls == K_LD);
                e.mem_write = (cls == K_ST);
                if (rst_mem) begin
                    step(e, 1'b0, 1'b0, 1'b0);
                    do_reset();
                end else begin
                    access(e, e, late, stl_mem);
                end
            end
            if (!rst_mem && cls != K_BR && cls != K_ST) begin
                e = o_st(5);
                e.reg_write = 1'b1;
                e.wb_sel = (cls == K_LD) ? 2'b01 : (cls == K_JAL || cls == K_JALR) ? 2'b10 : 2'b00;
                step(e, 1'b0, 1'b0, 1'b0);
            end
            e = o_st(1);
            e.imem_req = 1'b1;
            step(e, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic lit(input string nm, input int act, input int ex);
        lit_name = nm;
        lit_act = act;
        lit_exp = ex;
        lit_valid = 1'b1;
        @(negedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    initial begin
        // ADD x3,x1,x2: ready one cycle late, two stalled fetch cycles first
        run_instr("add_hs", 1'b0, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1, 2, 0, 1'b0);
        lit("add_reg_write_pulses", rw_cnt - b_rw, 1);
        lit("add_wb_cycles", wb_cnt - b_wb, 1);
        // LW with fixed 3-cycle memory
        run_instr("lw_lat3", 1'b1, 7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        lit("lw_mem_read_cycles", mr_cnt - b_mr, 3);
        lit("lw_reg_write_pulses", rw_cnt - b_rw, 1);
        // BEQ taken / not taken
        run_instr("beq_taken", 1'b0, 7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, 0, 1'b0);
        lit("beq_taken_pc_writes", pcw_cnt - b_pcw, 2);
        lit("beq_taken_no_wb", wb_cnt - b_wb, 0);
        run_instr("beq_not_taken", 1'b0, 7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        lit("beq_nt_pc_writes", pcw_cnt - b_pcw, 1);
        lit("beq_nt_reg_writes", rw_cnt - b_rw, 0);
        // JAL
        run_instr("jal", 1'b0, 7'b1101111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        lit("jal_pc_writes", pcw_cnt - b_pcw, 2);
        lit("jal_reg_writes", rw_cnt - b_rw, 1);
        // SW with 5 stalled cycles in MEM and a late ready
        run_instr("sw_stall", 1'b0, 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1, 0, 5, 1'b0);
        lit("sw_mem_write_cycles", mw_cnt - b_mw, 7);
        lit("sw_no_reg_write", rw_cnt - b_rw, 0);
        // SW interrupted by reset while in MEM
        run_instr("sw_reset_in_mem", 1'b0, 7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 0, 0, 1'b1);
        lit("sw_rst_mem_write_cycles", mw_cnt - b_mw, 1);
        // Remaining classes on the fixed-latency instance
        run_instr("lui", 1'b1, 7'b0110111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        run_instr("auipc", 1'b1, 7'b0010111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        run_instr("jalr", 1'b1, 7'b1100111, 3'b000, 7'b0000000, 1'b0, 0, 1, 0, 1'b0);
        run_instr("addi", 1'b1, 7'b0010011, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        run_instr("sub", 1'b1, 7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, 0, 1'b0);
        // Illegal encodings
        run_instr("op_bad_funct7", 1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b0, 0, 0, 0, 1'b0);
        run_instr("br_funct3_010", 1'b1, 7'b1100011, 3'b010, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        run_instr("trap_oneshot", 1'b1, 7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        lit("trap_oneshot_illegal_cycles", ill_cnt - b_ill, 1);
        lit("trap_oneshot_pc_writes", pcw_cnt - b_pcw, 2);
        run_instr("trap_sticky", 1'b0, 7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0, 1'b0);
        lit("trap_sticky_illegal_cycles", ill_cnt - b_ill, 20);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
